// File: rtl/i2c_byte_receiver.sv
// I2C slave-side byte receiver.
// Watches the debounced SCL/SDA pair, detects START/STOP, shifts in the
// address byte and write data bytes, and drives the ACK bit via sda_oe.
// Ports:
//   clk, rst        - system clock, asynchronous active-low reset
//   scl_db, sda_db  - debounced bus lines
//   rx_nack         - NACK request for the data byte being completed
//   start_det       - START / repeated START pulse
//   stop_det        - STOP pulse
//   addr_valid      - address byte complete pulse
//   addr_match      - address matched SLAVE_ADDR (level)
//   rw_flag         - R/W bit of the last address byte (level)
//   byte_valid      - write data byte complete pulse
//   byte_data       - last received data byte
//   sda_oe          - 1 = pull SDA low (ACK)
//   bus_busy        - high between START and STOP
module i2c_byte_receiver #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_db,
    input  logic       sda_db,
    input  logic       rx_nack,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_valid,
    output logic       addr_match,
    output logic       rw_flag,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       sda_oe,
    output logic       bus_busy
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t              state_q, state_d;
    logic                scl_q, scl_d;
    logic                sda_q, sda_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                ack_half_q, ack_half_d;   // first ACK-slot fall already seen
    logic                nack_q, nack_d;           // rx_nack captured on the 8th data rise
    logic                start_det_q, start_det_d;
    logic                stop_det_q, stop_det_d;
    logic                addr_valid_q, addr_valid_d;
    logic                addr_match_q, addr_match_d;
    logic                rw_flag_q, rw_flag_d;
    logic                byte_valid_q, byte_valid_d;
    logic [BYTE_W-1:0]   byte_data_q, byte_data_d;
    logic                sda_oe_q, sda_oe_d;
    logic                bus_busy_q, bus_busy_d;

    logic                start_c, stop_c, rise_c, fall_c;
    logic [BYTE_W-1:0]   byte_c;

    // Bus event decode; an SCL change masks any SDA change in the same cycle
    always_comb begin
        start_c = scl_q & scl_db & sda_q & ~sda_db;
        stop_c  = scl_q & scl_db & ~sda_q & sda_db;
        rise_c  = ~scl_q & scl_db;
        fall_c  = scl_q & ~scl_db;
        byte_c  = {shift_q[BYTE_W-2:0], sda_db};
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        scl_d        = scl_db;
        sda_d        = sda_db;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ack_half_d   = ack_half_q;
        nack_d       = nack_q;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        addr_valid_d = 1'b0;
        addr_match_d = addr_match_q;
        rw_flag_d    = rw_flag_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        sda_oe_d     = sda_oe_q;
        bus_busy_d   = bus_busy_q;

        if (start_c) begin
            state_d      = S_ADDR;
            cnt_d        = CNT_W'(0);
            ack_half_d   = 1'b0;
            sda_oe_d     = 1'b0;
            bus_busy_d   = 1'b1;
            addr_match_d = 1'b0;
            start_det_d  = 1'b1;
        end else if (stop_c) begin
            state_d      = S_IDLE;
            cnt_d        = CNT_W'(0);
            ack_half_d   = 1'b0;
            sda_oe_d     = 1'b0;
            bus_busy_d   = 1'b0;
            addr_match_d = 1'b0;
            stop_det_d   = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (rise_c) begin
                        shift_d = byte_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            addr_valid_d = 1'b1;
                            rw_flag_d    = byte_c[0];
                            addr_match_d = (byte_c[7:1] == SLAVE_ADDR);
                            ack_half_d   = 1'b0;
                            state_d      = (byte_c[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_DATA: begin
                    if (rise_c) begin
                        shift_d = byte_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            byte_data_d  = byte_c;
                            byte_valid_d = 1'b1;
                            nack_d       = rx_nack;
                            ack_half_d   = 1'b0;
                            state_d      = S_DATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    // First fall opens the ACK bit, second fall closes it
                    if (fall_c) begin
                        if (!ack_half_q) begin
                            sda_oe_d   = 1'b1;
                            ack_half_d = 1'b1;
                        end else begin
                            sda_oe_d   = 1'b0;
                            ack_half_d = 1'b0;
                            state_d    = rw_flag_q ? S_IGNORE : S_DATA;
                        end
                    end
                end
                S_DATA_ACK: begin
                    if (fall_c) begin
                        if (!ack_half_q) begin
                            sda_oe_d   = ~nack_q;
                            ack_half_d = 1'b1;
                        end else begin
                            sda_oe_d   = 1'b0;
                            ack_half_d = 1'b0;
                            state_d    = S_DATA;
                        end
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            scl_q        <= 1'b1;
            sda_q        <= 1'b1;
            cnt_q        <= CNT_W'(0);
            shift_q      <= BYTE_W'(0);
            ack_half_q   <= 1'b0;
            nack_q       <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            addr_valid_q <= 1'b0;
            addr_match_q <= 1'b0;
            rw_flag_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= BYTE_W'(0);
            sda_oe_q     <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_q        <= scl_d;
            sda_q        <= sda_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            ack_half_q   <= ack_half_d;
            nack_q       <= nack_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            addr_valid_q <= addr_valid_d;
            addr_match_q <= addr_match_d;
            rw_flag_q    <= rw_flag_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            sda_oe_q     <= sda_oe_d;
            bus_busy_q   <= bus_busy_d;
        end
    end

    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;
    assign addr_valid = addr_valid_q;
    assign addr_match = addr_match_q;
    assign rw_flag    = rw_flag_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign sda_oe     = sda_oe_q;
    assign bus_busy   = bus_busy_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Directed bench for i2c_byte_receiver with an expected-event scoreboard.
module tb_i2c_byte_receiver;

    localparam int unsigned HOLD = 4;

    logic       clk;
    logic       rst;
    logic       scl_db;
    logic       sda_db;
    logic       rx_nack;
    logic       start_det;
    logic       stop_det;
    logic       addr_valid;
    logic       addr_match;
    logic       rw_flag;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       sda_oe;
    logic       bus_busy;

    i2c_byte_receiver #(.SLAVE_ADDR(7'h50)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_db     (scl_db),
        .sda_db     (sda_db),
        .rx_nack    (rx_nack),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .addr_valid (addr_valid),
        .addr_match (addr_match),
        .rw_flag    (rw_flag),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .sda_oe     (sda_oe),
        .bus_busy   (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0] addr_exp_q[$];   // {addr_match, rw_flag}
    logic [7:0] byte_exp_q[$];
    logic [1:0] addr_e;
    logic [7:0] byte_e;

    int start_cnt  = 0;
    int stop_cnt   = 0;
    int exp_start  = 0;
    int exp_stop   = 0;
    int oe_viol    = 0;
    int unexp_addr = 0;
    int unexp_byte = 0;
    logic oe_allowed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT reports an event
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (start_det === 1'b1) start_cnt++;
            if (stop_det === 1'b1) stop_cnt++;
            if (sda_oe !== 1'b0 && !oe_allowed) oe_viol++;
            if (addr_valid === 1'b1) begin
                if (addr_exp_q.size() == 0) unexp_addr++;
                else begin
                    addr_e = addr_exp_q.pop_front();
                    check("addr_match", 32'(addr_match), 32'(addr_e[1]));
                    check("rw_flag", 32'(rw_flag), 32'(addr_e[0]));
                end
            end
            if (byte_valid === 1'b1) begin
                if (byte_exp_q.size() == 0) unexp_byte++;
                else begin
                    byte_e = byte_exp_q.pop_front();
                    check("byte_data", 32'(byte_data), 32'(byte_e));
                end
            end
        end
    end

    task automatic drive(input logic scl, input logic sda);
        scl_db = scl;
        sda_db = sda;
        repeat (HOLD) @(negedge clk);
    endtask

    // Works from idle and as a repeated START (SCL low on entry)
    task automatic send_start();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        exp_start++;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic send_stop();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        exp_stop++;
        drive(1'b1, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        drive(1'b0, b);
        drive(1'b1, b);
        drive(1'b0, b);
    endtask

    // Byte followed by the ACK slot; ack_exp is the expected sda_oe in that slot
    task automatic send_byte_ack(input logic [7:0] b, input logic ack_exp, input string tag);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, v[i]);
            drive(1'b1, v[i]);
            if (i == 0) oe_allowed = ack_exp;
            drive(1'b0, v[i]);
        end
        check({tag, "_ack_low"}, 32'(sda_oe), 32'(ack_exp));
        drive(1'b1, 1'b1);
        check({tag, "_ack_high"}, 32'(sda_oe), 32'(ack_exp));
        drive(1'b0, 1'b1);
        oe_allowed = 1'b0;
        check({tag, "_ack_release"}, 32'(sda_oe), 32'(0));
    endtask

    initial begin
        logic [7:0] a0;
        rst     = 1'b0;
        scl_db  = 1'b1;
        sda_db  = 1'b1;
        rx_nack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_start_det", 32'(start_det), 32'(0));
        check("rst_stop_det", 32'(stop_det), 32'(0));
        check("rst_addr_valid", 32'(addr_valid), 32'(0));
        check("rst_addr_match", 32'(addr_match), 32'(0));
        check("rst_rw_flag", 32'(rw_flag), 32'(0));
        check("rst_byte_valid", 32'(byte_valid), 32'(0));
        check("rst_byte_data", 32'(byte_data), 32'(0));
        check("rst_sda_oe", 32'(sda_oe), 32'(0));
        check("rst_bus_busy", 32'(bus_busy), 32'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Matching write of 0x3C, ACKed, then STOP
        send_start();
        check("t1_start_cnt", 32'(start_cnt), 32'(exp_start));
        check("t1_busy", 32'(bus_busy), 32'(1));
        addr_exp_q.push_back(2'b10);
        send_byte_ack(8'hA0, 1'b1, "t1_addr");
        check("t1_match_level", 32'(addr_match), 32'(1));
        byte_exp_q.push_back(8'h3C);
        send_byte_ack(8'h3C, 1'b1, "t1_data");
        send_stop();
        check("t1_stop_cnt", 32'(stop_cnt), 32'(exp_stop));
        check("t1_busy_off", 32'(bus_busy), 32'(0));
        check("t1_match_clr", 32'(addr_match), 32'(0));
        check("t1_byte_hold", 32'(byte_data), 32'(8'h3C));

        // Non-matching address: no ACK, no data bytes
        send_start();
        addr_exp_q.push_back(2'b00);
        send_byte_ack(8'hA2, 1'b0, "t2_addr");
        check("t2_match_level", 32'(addr_match), 32'(0));
        send_byte_ack(8'h55, 1'b0, "t2_d0");
        send_byte_ack(8'h12, 1'b0, "t2_d1");
        check("t2_busy", 32'(bus_busy), 32'(1));
        send_stop();
        check("t2_byte_hold", 32'(byte_data), 32'(8'h3C));

        // NACKed byte followed by an ACKed byte
        send_start();
        addr_exp_q.push_back(2'b10);
        send_byte_ack(8'hA0, 1'b1, "t3_addr");
        rx_nack = 1'b1;
        byte_exp_q.push_back(8'hFF);
        send_byte_ack(8'hFF, 1'b0, "t3_nack");
        rx_nack = 1'b0;
        byte_exp_q.push_back(8'h81);
        send_byte_ack(8'h81, 1'b1, "t3_next");
        send_stop();

        // Repeated START after 3 data bits, then a read address
        send_start();
        addr_exp_q.push_back(2'b10);
        send_byte_ack(8'hA0, 1'b1, "t4_addr");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_start();
        check("t4_rstart_cnt", 32'(start_cnt), 32'(exp_start));
        check("t4_busy", 32'(bus_busy), 32'(1));
        addr_exp_q.push_back(2'b11);
        send_byte_ack(8'hA1, 1'b1, "t4_raddr");
        send_byte_ack(8'h77, 1'b0, "t4_read");
        send_stop();
        check("t4_rw_level", 32'(rw_flag), 32'(1));
        check("t4_match_clr", 32'(addr_match), 32'(0));

        // Reset while ACK is being driven
        send_start();
        addr_exp_q.push_back(2'b10);
        a0 = 8'hA0;
        for (int i = 7; i >= 1; i--) send_bit(a0[i]);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        oe_allowed = 1'b1;
        drive(1'b0, 1'b0);
        check("t5_oe_before_rst", 32'(sda_oe), 32'(1));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_oe_async", 32'(sda_oe), 32'(0));
        check("t5_busy_async", 32'(bus_busy), 32'(0));
        oe_allowed = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Bit traffic without START is ignored
        for (int i = 7; i >= 0; i--) send_bit(a0[i]);
        check("t5_idle_busy", 32'(bus_busy), 32'(0));
        check("t5_idle_oe", 32'(sda_oe), 32'(0));

        // SCL and SDA moving together never form START/STOP
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        check("t6_start_cnt", 32'(start_cnt), 32'(exp_start));
        check("t6_stop_cnt", 32'(stop_cnt), 32'(exp_stop));
        check("t6_busy", 32'(bus_busy), 32'(0));

        // Scoreboard drain
        repeat (4) @(negedge clk);
        check("addr_q_left", 32'(addr_exp_q.size()), 32'(0));
        check("byte_q_left", 32'(byte_exp_q.size()), 32'(0));
        check("unexp_addr", 32'(unexp_addr), 32'(0));
        check("unexp_byte", 32'(unexp_byte), 32'(0));
        check("oe_viol", 32'(oe_viol), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
